mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  RV64 memory-stage load/store unit between EX/MEM and MEM/WB pipeline registers.
//  Issues one data-memory transaction per load/store over a req/ack bus; stalls pipeline until done.
//  Produces byte-lane-aligned, sign/zero-extended ReadData for MEM/WB capture.
// PARAMETERS
//  XLEN         64   datapath and address width
//  TIMEOUT_CYC  255  max WAIT cycles before bus error (8-bit counter)
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous, active-high reset
//  MemReadM   in   1     load in MEM stage
//  MemWriteM  in   1     store in MEM stage
//  Funct3M    in   3     access size/sign (RV64 load/store funct3)
//  ALUResultM in   64    effective byte address
//  WriteDataM in   64    store data (rs2), LSB-justified
//  ReadData   out  64    registered, extended load result
//  StallM     out  1     freeze IF..MEM stages and hold MEM/WB inputs
//  BusErrM    out  1     1-cycle pulse: transaction timed out
//  MisalignM  out  1     1-cycle pulse: misaligned access (tied 0 without macro)
//  dmem_req   out  1     request valid, held until dmem_ack
//  dmem_we    out  1     1 = write
//  dmem_addr  out  64    8-byte-aligned address (addr[2:0]=0)
//  dmem_wdata out  64    lane-shifted store data
//  dmem_be    out  8     byte enables
//  dmem_ack   in   1     transaction complete (rdata valid same cycle)
//  dmem_rdata in   64    aligned read doubleword
// BEHAVIOUR
//  Reset: state IDLE, ReadData=0, dmem_req/we=0, dmem_addr/wdata=0, dmem_be=0, BusErrM=0, timer=0.
//  StallM combinational, forced 0 while rst.
//  FSM IDLE->WAIT->DONE->IDLE.
//   IDLE: valid access present -> StallM=1; register req=1, addr, we, be, wdata; go WAIT.
//   WAIT: req held, StallM=1, timer++. ack -> req=0, latch formatted rdata (loads), go DONE.
//         timer==TIMEOUT_CYC w/o ack -> req=0, ReadData=0, BusErrM=1 next cycle, go DONE.
//   DONE: StallM=0 one cycle (pipeline advances, MEM/WB samples ReadData); go IDLE.
//  Min latency: ack in first WAIT cycle -> 2 stall cycles, result valid in DONE.
//  Store: ReadData unchanged. ack in same cycle as timeout expiry: ack wins.
//  MemReadM & MemWriteM both 1: treated as store. Illegal funct3 (load 7, store >3): no bus
//   access, no stall, ReadData unchanged.
//  Lanes: off=addr[2:0]; size B/H/W/D mask 0x01/0x03/0x0F/0xFF; be=mask<<off;
//   wdata=WriteDataM<<(8*off); load=rdata>>(8*off) then sign(f3 0-3)/zero(f3 4-6) extend.
//  Bus must tolerate request withdrawn by reset; rst in WAIT -> req=0 next edge, IDLE.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: addr not multiple of size -> no bus access, no stall,
//   MisalignM pulses 1 cycle in IDLE (combinational), ReadData unchanged.
//  Undefined: MisalignM=0; addr low bits masked to natural alignment (addr & ~(size-1)).
// STRUCTURE
//  lsu_pkg: FSM state encoding, funct3 constants (LB..LWU, SB..SD), size-mask function.
//  Sub-module lsu_lane_align (comb.): be/wdata generation and load shift/extend.
// TESTING
//  LD addr 0x1000, rdata 0x8877665544332211, ack 1st WAIT -> StallM 2 cycles, ReadData=0x8877665544332211.
//  LB addr 0x1003, rdata byte3=0x80 -> dmem_addr 0x1000, be 0x08, ReadData=0xFFFFFFFFFFFFFF80; LBU -> 0x80.
//  SH addr 0x1006, rs2=0xBEEF -> be 0xC0, wdata=0xBEEF000000000000, we=1, ReadData unchanged.
//  No ack for 255 WAIT cycles -> BusErrM pulse, ReadData=0, StallM drops in DONE.
//  LW addr 0x1002: with macro MisalignM=1, no req; without, dmem_addr 0x1000, be 0x0F.
//  rst asserted mid-WAIT -> req=0, all outputs reset values next cycle, next LD completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit:
// FSM encoding, RV64 load/store funct3 codes and access-size helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    localparam logic [2:0] F3_SB = 3'd0;
    localparam logic [2:0] F3_SH = 3'd1;
    localparam logic [2:0] F3_SW = 3'd2;
    localparam logic [2:0] F3_SD = 3'd3;

    // Byte-enable pattern for an access of 1/2/4/8 bytes at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] size_lowbits(input logic [1:0] size);
        case (size)
            2'd0:    size_lowbits = 3'b000;
            2'd1:    size_lowbits = 3'b001;
            2'd2:    size_lowbits = 3'b011;
            default: size_lowbits = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and data shift,
// load data shift and sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [5:0]      sh_amt;
    logic [XLEN-1:0] sh;

    always_comb begin
        sh_amt = {off, 3'b000};
        be     = size_mask(funct3[1:0]) << off;
        wdata  = store_data << sh_amt;
        sh     = rdata >> sh_amt;
    end

    always_comb begin
        load_data = sh;
        case (funct3)
            F3_LB:   load_data = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_LH:   load_data = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_LW:   load_data = {{(XLEN-32){sh[31]}}, sh[31:0]};
            F3_LD:   load_data = sh;
            F3_LBU:  load_data = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_LHU:  load_data = {{(XLEN-16){1'b0}}, sh[15:0]};
            F3_LWU:  load_data = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: load_data = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV64 memory-stage load/store unit: one req/ack bus transaction per access, stalling the
// pipeline until done. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses via MisalignM.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadData,
    output logic            StallM,
    output logic            BusErrM,
    output logic            MisalignM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_be,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata
);

    lsu_state_e state_q, state_d;

    logic [7:0]      timer_q;
    logic [2:0]      f3_q;
    logic [2:0]      off_q;
    logic            load_q;
    logic [XLEN-1:0] read_data_q;
    logic            bus_err_q;
    logic            req_q;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [7:0]      be_q;

    logic            access;
    logic            legal;
    logic            mis_block;
    logic            launch;
    logic            timeout;
    logic [2:0]      off_in;
    logic [2:0]      f3_sel;
    logic [2:0]      off_sel;
    logic [7:0]      la_be;
    logic [XLEN-1:0] la_wdata;
    logic [XLEN-1:0] la_load;

    always_comb begin
        access = MemReadM | MemWriteM;
        // A simultaneous read+write request is handled as a store.
        if (MemWriteM) begin
            legal = Funct3M inside {F3_SB, F3_SH, F3_SW, F3_SD};
        end else begin
            legal = Funct3M <= F3_LWU;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        mis_block = |(ALUResultM[2:0] & size_lowbits(Funct3M[1:0]));
        off_in    = ALUResultM[2:0];
`else
        mis_block = 1'b0;
        off_in    = ALUResultM[2:0] & ~size_lowbits(Funct3M[1:0]);
`endif
        launch  = (state_q == StIdle) && access && legal && !mis_block;
        timeout = (timer_q == 8'(TIMEOUT_CYC));
        // Live inputs drive the store lanes at launch; latched ones format the load at ack.
        f3_sel  = (state_q == StIdle) ? Funct3M : f3_q;
        off_sel = (state_q == StIdle) ? off_in  : off_q;
    end

    lsu_lane_align #(
        .XLEN(XLEN)
    ) u_lane_align (
        .funct3    (f3_sel),
        .off       (off_sel),
        .store_data(WriteDataM),
        .rdata     (dmem_rdata),
        .be        (la_be),
        .wdata     (la_wdata),
        .load_data (la_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (launch) state_d = StWait;
            StWait:  if (dmem_ack || timeout) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        StallM    = !rst && (launch || (state_q == StWait));
        MisalignM = !rst && (state_q == StIdle) && access && legal && mis_block;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q     <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            load_q      <= 1'b0;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (launch) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWriteM;
                        addr_q  <= {ALUResultM[XLEN-1:3], 3'b000};
                        be_q    <= la_be;
                        wdata_q <= la_wdata;
                        f3_q    <= Funct3M;
                        off_q   <= off_in;
                        load_q  <= !MemWriteM;
                        timer_q <= 8'd1;
                    end
                end
                StWait: begin
                    if (dmem_ack) begin
                        req_q <= 1'b0;
                        if (load_q) read_data_q <= la_load;
                    end else if (timeout) begin
                        req_q       <= 1'b0;
                        read_data_q <= '0;
                        bus_err_q   <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: timer_q <= '0;
            endcase
        end
    end

    assign ReadData   = read_data_q;
    assign BusErrM    = bus_err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed cases plus randomized accesses
// checked against a byte-level reference model.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [63:0] ALUResultM, WriteDataM;
    logic [63:0] ReadData;
    logic        StallM, BusErrM, MisalignM;
    logic        dmem_req, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_rd;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk       (clk),
        .rst       (rst),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .Funct3M   (Funct3M),
        .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM),
        .ReadData  (ReadData),
        .StallM    (StallM),
        .BusErrM   (BusErrM),
        .MisalignM (MisalignM),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be   (dmem_be),
        .dmem_ack  (dmem_ack),
        .dmem_rdata(dmem_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference load result: pick bytes, then extend by the funct3 rule.
    function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off,
                                             input logic [63:0] rdata);
        int size;
        logic [63:0] v;
        size = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
        return v;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int ack_wait);
        logic store, legal, mis, launch, acked;
        int size, off, n;
        logic [63:0] mask;
        store  = wr;
        size   = 1 << f3[1:0];
        legal  = (rd || wr) && (store ? (f3 < 3'd4) : (f3 != 3'd7));
        mis    = (addr % size) != 0;
        launch = legal && !(TrapEn && mis);
        off    = TrapEn ? int'(addr % 8) : int'(addr % 8) - int'((addr % 8) % size);
        mask   = ((64'd1 << size) - 64'd1) << off;

        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = sdata;
        dmem_ack = 1'b0;
        @(negedge clk);
        check({tag, ".stall_idle"}, StallM, launch);
        check({tag, ".misalign"}, MisalignM, legal && mis && TrapEn);
        @(posedge clk); #1;
        if (!launch) begin
            check({tag, ".no_req"}, dmem_req, 1'b0);
            check({tag, ".rd_hold"}, ReadData, exp_rd);
            MemReadM = 1'b0; MemWriteM = 1'b0;
            return;
        end
        check({tag, ".req"}, dmem_req, 1'b1);
        check({tag, ".we"}, dmem_we, store);
        check({tag, ".addr"}, dmem_addr, addr & ~64'd7);
        check({tag, ".be"}, dmem_be, mask[7:0]);
        if (store) check({tag, ".wdata"}, dmem_wdata, sdata << (8*off));
        acked = 1'b0;
        n = 1;
        while (1) begin
            if (n == ack_wait) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
            check({tag, ".stall_wait"}, StallM, 1'b1);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            if (n == ack_wait) begin
                acked = 1'b1;
                break;
            end
            if (n == 255) break;
            n++;
        end
        if (!acked) exp_rd = '0;
        else if (!store) exp_rd = ref_load(f3, off, rdata);
        @(negedge clk);
        check({tag, ".stall_done"}, StallM, 1'b0);
        check({tag, ".req_done"}, dmem_req, 1'b0);
        check({tag, ".buserr"}, BusErrM, !acked);
        check({tag, ".rdata"}, ReadData, exp_rd);
        @(posedge clk); #1;
        MemReadM = 1'b0; MemWriteM = 1'b0;
        check({tag, ".buserr_clr"}, BusErrM, 1'b0);
    endtask

    initial begin
        logic [63:0] a, d, r;
        logic [2:0]  f;
        logic        w;
        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
        MemReadM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'd3; ALUResultM = 64'h1000;
        WriteDataM = '0;
        exp_rd = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst.stall", StallM, 1'b0);
        check("rst.misalign", MisalignM, 1'b0);
        check("rst.req", dmem_req, 1'b0);
        check("rst.we", dmem_we, 1'b0);
        check("rst.addr", dmem_addr, 64'd0);
        check("rst.wdata", dmem_wdata, 64'd0);
        check("rst.be", {56'd0, dmem_be}, 64'd0);
        check("rst.rd", ReadData, 64'd0);
        check("rst.buserr", BusErrM, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;

        access("ld", 1, 0, 3'd3, 64'h1000, 0, 64'h8877665544332211, 1);
        access("lb", 1, 0, 3'd0, 64'h1003, 0, 64'h1122334480AABBCC, 2);
        access("lbu", 1, 0, 3'd4, 64'h1003, 0, 64'h1122334480AABBCC, 1);
        access("sh", 0, 1, 3'd1, 64'h1006, 64'hBEEF, 0, 1);
        access("lwu", 1, 0, 3'd6, 64'h1004, 0, 64'h80000001_00000000, 3);
        access("lh", 1, 0, 3'd1, 64'h1002, 0, 64'h00000000_9ABC0000, 1);
        access("timeout", 1, 0, 3'd3, 64'h1008, 0, 64'h1234, 0);
        access("ack255", 1, 0, 3'd2, 64'h1010, 0, 64'h00000000_7FFFFFFF, 255);
        access("lw_mis", 1, 0, 3'd2, 64'h1002, 0, 64'h00000000_87654321, 1);
        access("ill_ld", 1, 0, 3'd7, 64'h1000, 0, 64'hFFFF, 1);
        access("ill_st", 0, 1, 3'd5, 64'h1000, 64'h55, 0, 1);
        access("rdwr", 1, 1, 3'd3, 64'h1018, 64'hCAFEF00D_12345678, 64'hFFFF, 1);

        // Reset while a load is outstanding.
        MemReadM = 1'b1; Funct3M = 3'd3; ALUResultM = 64'h2000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstw.stall", StallM, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; MemReadM = 1'b0;
        exp_rd = '0;
        check("rstw.req", dmem_req, 1'b0);
        check("rstw.addr", dmem_addr, 64'd0);
        check("rstw.be", {56'd0, dmem_be}, 64'd0);
        check("rstw.rd", ReadData, 64'd0);
        check("rstw.buserr", BusErrM, 1'b0);
        access("ld_after_rst", 1, 0, 3'd3, 64'h2000, 0, 64'h0123456789ABCDEF, 2);

        for (int i = 0; i < 60; i++) begin
            a = {32'h0, $urandom} & ~64'h0 ^ {$urandom, 32'h0};
            d = {$urandom, $urandom};
            r = {$urandom, $urandom};
            f = 3'($urandom_range(0, 7));
            w = ($urandom_range(0, 2) == 0);
            access("rand", !w || ($urandom_range(0, 4) == 0), w, f, a, d, r,
                   $urandom_range(1, 5));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
